// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch front end: fetch FSM encoding and
// default PC reset value / sequential step.
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_KILL = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          PC_STEP_DEFAULT  = 4;

endpackage

// File: rtl/pc_fetch_unit_mux2x1.sv
// Two-input word select used for next-PC choice (sequential vs redirect target).
module Mux2x1 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data_0_i,
  input  logic [WIDTH-1:0] data_1_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] data_o
);

  assign data_o = sel_i ? data_1_i : data_0_i;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter plus single-outstanding instruction fetch over req/ack, feeding a
// one-entry valid/ready buffer toward IF/ID. EX redirects discard wrong-path fetches.
module pc_fetch_unit
  import riscv_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT),
  parameter int               PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             stall,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [WIDTH-1:0] if_pc,
  output logic [WIDTH-1:0] if_instr,
  output fetch_state_e     dbg_state
);

  // Handshakes: imem_req/imem_addr hold until the cycle imem_ack is sampled high;
  // the output buffer transfers on any rising edge where if_valid & if_ready.

  fetch_state_e     state_q;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] req_addr_q;
  logic             if_valid_q;
  logic [WIDTH-1:0] if_pc_q, if_instr_q;
  logic [WIDTH-1:0] pc_seq, pc_mux;
  logic             fill, issue;

  assign pc_seq = pc_q + WIDTH'(PC_STEP);

  Mux2x1 #(.WIDTH(WIDTH)) u_next_pc_mux (
    .data_0_i (pc_seq),
    .data_1_i (branch_target),
    .sel_i    (branch_taken),
    .data_o   (pc_mux)
  );

  // A live response only counts when no redirect lands on the same edge.
  assign fill  = (state_q == ST_REQ) && imem_ack && !branch_taken;
  assign issue = !stall && !branch_taken && (!if_valid_q || if_ready);
  assign pc_d  = (branch_taken || fill) ? pc_mux : pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
    end else begin
      pc_q <= pc_d;

      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            state_q    <= ST_REQ;
            req_addr_q <= pc_q;
          end
        end
        ST_REQ: begin
          if (branch_taken) begin
            state_q <= imem_ack ? ST_IDLE : ST_KILL;
          end else if (imem_ack) begin
            state_q <= ST_IDLE;
          end
        end
        ST_KILL: begin
          if (imem_ack) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Flush wins over both a fill and a consume on the same edge.
      if (branch_taken) begin
        if_valid_q <= 1'b0;
      end else if (fill) begin
        if_valid_q <= 1'b1;
        if_pc_q    <= req_addr_q;
        if_instr_q <= imem_rdata;
      end else if (if_valid_q && if_ready) begin
        if_valid_q <= 1'b0;
      end
    end
  end

  assign imem_req  = (state_q != ST_IDLE);
  assign imem_addr = req_addr_q;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed vector table, hand-written corner
// sequences, then randomized traffic against a transaction-level fetch model.
module tb_pc_fetch_unit;
  import riscv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         branch_taken = 1'b0;
  logic [W-1:0] branch_target = '0;
  logic         stall = 1'b0;
  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic         imem_ack = 1'b0;
  logic [W-1:0] imem_rdata = '0;
  logic         if_valid;
  logic         if_ready = 1'b0;
  logic [W-1:0] if_pc;
  logic [W-1:0] if_instr;
  fetch_state_e dbg_state;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  pc_fetch_unit #(.WIDTH(W), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    branch_taken = 1'b0; branch_target = '0; stall = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0; if_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return a * 32'h9E37_79B1 + 32'h0000_0013;
  endfunction

  // ---------------- vector driver ----------------
  typedef struct {
    logic         stall;
    logic         ready;
    logic         br;
    logic [W-1:0] tgt;
    logic         ack;
    logic [W-1:0] rdata;
    logic         e_req;
    logic [W-1:0] e_addr;
    logic         e_valid;
    logic [W-1:0] e_pc;
    logic [W-1:0] e_instr;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic r, input logic b, input logic [W-1:0] t,
                              input logic a, input logic [W-1:0] d, input logic er,
                              input logic [W-1:0] ea, input logic ev, input logic [W-1:0] ep,
                              input logic [W-1:0] ei);
    vec_t v;
    v.stall = s; v.ready = r; v.br = b; v.tgt = t; v.ack = a; v.rdata = d;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_instr = ei;
    return v;
  endfunction

  // Inputs are set at the falling edge, outputs are checked at the next falling edge.
  task automatic apply_vec(input string tag, input vec_t v);
    stall = v.stall; if_ready = v.ready; branch_taken = v.br; branch_target = v.tgt;
    imem_ack = v.ack; imem_rdata = v.rdata;
    @(posedge clk);
    @(negedge clk);
    check($sformatf("%s.req", tag), 32'(imem_req), 32'(v.e_req));
    check($sformatf("%s.addr", tag), imem_addr, v.e_addr);
    check($sformatf("%s.valid", tag), 32'(if_valid), 32'(v.e_valid));
    if (v.e_valid) begin
      check($sformatf("%s.pc", tag), if_pc, v.e_pc);
      check($sformatf("%s.instr", tag), if_instr, v.e_instr);
    end
  endtask

  localparam logic [W-1:0] I0 = 32'h0050_0093;
  localparam logic [W-1:0] I1 = 32'h00A0_0113;
  localparam logic [W-1:0] I2 = 32'h00C0_0193;
  localparam logic [W-1:0] JUNK = 32'hDEAD_BEEF;

  // ---------------- random phase state ----------------
  logic         prev_req, prev_ack, issue_ok_prev, first, live;
  logic         pend_fill, pend_flush;
  logic [W-1:0] prev_addr, exp_fetch, pend_addr, e;
  int           wait_cnt, delay, consumed;

  initial begin
    vec_t tbl[7];

    // ---- reset values ----
    do_reset();
    check("rst.req", 32'(imem_req), 0);
    check("rst.valid", 32'(if_valid), 0);
    check("rst.addr", imem_addr, 32'h0);
    check("rst.pc", if_pc, 32'h0);
    check("rst.instr", if_instr, 32'h0);
    check("rst.state", 32'(dbg_state), 32'(ST_IDLE));

    // ---- table: sequential fetch with back-pressure then free flow ----
    tbl[0] = mk(0, 0, 0, 0, 0, 0,  1, 32'h0, 0, 0, 0);
    tbl[1] = mk(0, 0, 0, 0, 1, I0, 0, 32'h0, 1, 32'h0, I0);
    tbl[2] = mk(0, 0, 0, 0, 0, 0,  0, 32'h0, 1, 32'h0, I0);
    tbl[3] = mk(0, 0, 0, 0, 0, 0,  0, 32'h0, 1, 32'h0, I0);
    tbl[4] = mk(0, 1, 0, 0, 0, 0,  1, 32'h4, 0, 0, 0);
    tbl[5] = mk(0, 1, 0, 0, 1, I1, 0, 32'h4, 1, 32'h4, I1);
    tbl[6] = mk(0, 1, 0, 0, 0, 0,  1, 32'h8, 0, 0, 0);
    for (int i = 0; i < 7; i++) apply_vec($sformatf("tbl%0d", i), tbl[i]);

    // ---- redirect while request to 0x8 waits; ack arrives 3 cycles late ----
    apply_vec("late.wait", mk(0, 1, 0, 0, 0, 0, 1, 32'h8, 0, 0, 0));
    apply_vec("late.br",   mk(0, 1, 1, 32'h100, 0, 0, 1, 32'h8, 0, 0, 0));
    apply_vec("late.kill", mk(0, 1, 0, 0, 0, 0, 1, 32'h8, 0, 0, 0));
    apply_vec("late.ack",  mk(0, 1, 0, 0, 1, JUNK, 0, 32'h8, 0, 0, 0));
    apply_vec("late.next", mk(0, 1, 0, 0, 0, 0, 1, 32'h100, 0, 0, 0));

    // ---- redirect on the ack edge, flush of a held buffer, redirect beats consume ----
    apply_vec("same.fill", mk(0, 1, 0, 0, 1, I0, 0, 32'h100, 1, 32'h100, I0));
    apply_vec("same.req",  mk(0, 1, 0, 0, 0, 0, 1, 32'h104, 0, 0, 0));
    apply_vec("same.brack", mk(0, 1, 1, 32'h200, 1, I1, 0, 32'h104, 0, 0, 0));
    apply_vec("same.next", mk(0, 0, 0, 0, 0, 0, 1, 32'h200, 0, 0, 0));
    apply_vec("hold.fill", mk(0, 0, 0, 0, 1, I2, 0, 32'h200, 1, 32'h200, I2));
    apply_vec("hold.flush", mk(0, 0, 1, 32'h300, 0, 0, 0, 32'h200, 0, 0, 0));
    apply_vec("hold.next", mk(0, 1, 0, 0, 0, 0, 1, 32'h300, 0, 0, 0));
    apply_vec("race.fill", mk(0, 1, 0, 0, 1, I0, 0, 32'h300, 1, 32'h300, I0));
    apply_vec("race.br",   mk(0, 1, 1, 32'h400, 0, 0, 0, 32'h300, 0, 0, 0));
    apply_vec("race.next", mk(0, 1, 0, 0, 0, 0, 1, 32'h400, 0, 0, 0));

    // ---- stall: in-flight ack still delivered, no new request for 5 cycles ----
    apply_vec("stall.fill", mk(1, 0, 0, 0, 1, I1, 0, 32'h400, 1, 32'h400, I1));
    for (int i = 0; i < 5; i++)
      apply_vec($sformatf("stall.hold%0d", i), mk(1, 1, 0, 0, 0, 0, 0, 32'h400, 0, 0, 0));
    apply_vec("stall.resume", mk(0, 1, 0, 0, 0, 0, 1, 32'h404, 0, 0, 0));

    // ---- wrap of pc 0xFFFF_FFFC ----
    apply_vec("wrap.br",   mk(0, 1, 1, 32'hFFFF_FFFC, 1, I2, 0, 32'h404, 0, 0, 0));
    apply_vec("wrap.req",  mk(0, 1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0));
    apply_vec("wrap.fill", mk(0, 1, 0, 0, 1, I0, 0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, I0));
    apply_vec("wrap.next", mk(0, 1, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0));
    apply_vec("wrap.fill2", mk(0, 1, 0, 0, 1, I1, 0, 32'h0, 1, 32'h0, I1));
    apply_vec("wrap.next2", mk(0, 1, 0, 0, 0, 0, 1, 32'h4, 0, 0, 0));

    // ---- asynchronous reset while a request is outstanding ----
    #2 rst = 1'b1;
    #1;
    check("arst.req", 32'(imem_req), 0);
    check("arst.valid", 32'(if_valid), 0);
    check("arst.addr", imem_addr, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    apply_vec("arst.lateack", mk(0, 1, 0, 0, 1, JUNK, 1, 32'h0, 0, 0, 0));
    apply_vec("arst.fill",    mk(0, 1, 0, 0, 1, I2, 0, 32'h0, 1, 32'h0, I2));

    // ---- randomized traffic against a transaction-level model ----
    do_reset();
    exp_q.delete();
    first = 1'b1; live = 1'b0; prev_req = 1'b0; prev_ack = 1'b0; issue_ok_prev = 1'b0;
    pend_fill = 1'b0; pend_flush = 1'b0; prev_addr = '0; pend_addr = '0;
    exp_fetch = 32'h0; wait_cnt = 0; delay = 0; consumed = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (!first) begin
        if (prev_req && !prev_ack) begin
          check("rnd.hold_req", 32'(imem_req), 1);
          check("rnd.hold_addr", imem_addr, prev_addr);
        end
        if (prev_ack) check("rnd.req_drop", 32'(imem_req), 0);
        if (!prev_req) check("rnd.issue_rule", 32'(imem_req), 32'(issue_ok_prev));
        if (pend_fill) begin
          check("rnd.fill_valid", 32'(if_valid), 1);
          check("rnd.fill_pc", if_pc, pend_addr);
          check("rnd.fill_instr", if_instr, mem_word(pend_addr));
        end
        if (pend_flush) check("rnd.flush_valid", 32'(if_valid), 0);
      end
      if (!prev_req && imem_req) begin
        check("rnd.fetch_addr", imem_addr, exp_fetch);
        live = 1'b1;
        wait_cnt = 0;
        delay = $urandom_range(0, 3);
      end
      first = 1'b0;

      stall = ($urandom_range(0, 9) == 0);
      if_ready = ($urandom_range(0, 3) != 0);
      branch_taken = ($urandom_range(0, 19) == 0);
      branch_target = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFC : (32'($urandom_range(0, 1023)) << 2);
      imem_ack = 1'b0;
      imem_rdata = JUNK;
      if (imem_req) begin
        if (wait_cnt >= delay) begin
          imem_ack = 1'b1;
          imem_rdata = mem_word(imem_addr);
        end else begin
          wait_cnt++;
        end
      end

      // Model of what this rising edge does.
      issue_ok_prev = !stall && !branch_taken && (!if_valid || if_ready);
      pend_fill = 1'b0;
      pend_flush = 1'b0;
      if (branch_taken) begin
        exp_fetch = branch_target;
        live = 1'b0;
        exp_q.delete();
        pend_flush = 1'b1;
      end else begin
        if (if_valid && if_ready) begin
          check("rnd.consume_expected", 32'(exp_q.size()), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rnd.consume_pc", if_pc, e);
            check("rnd.consume_instr", if_instr, mem_word(e));
            consumed++;
          end
        end
        if (imem_ack && live) begin
          exp_q.push_back(exp_fetch);
          pend_fill = 1'b1;
          pend_addr = exp_fetch;
          exp_fetch = exp_fetch + 32'd4;
          live = 1'b0;
        end
      end
      prev_req = imem_req;
      prev_addr = imem_addr;
      prev_ack = imem_ack;
      @(posedge clk);
      @(negedge clk);
    end
    check("rnd.progress", 32'(consumed > 200), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
